// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with IF/ID register, one-word skid and redirect.
// Optional: FETCH_PERF_CNT_EN adds a saturating fetch_count of instructions delivered to decode.
module fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        PCsrc,
  input  logic        JSel,
  input  logic        JrSel,
  input  logic [31:0] branch_imm,
  input  logic [31:0] jr_addr,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic [31:0] pc_plus4,
  output logic        valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic [31:0] skid_q, skid_d;
  logic        valid_q, valid_d;
  logic        imem_req_q;
  logic        redirect;
  logic        deliver;
  logic [31:0] deliver_word;
  logic [31:0] target;
  logic [31:0] seq_pc;

  assign seq_pc   = pc_q + 32'd4;
  assign redirect = valid_q && !stall && (JrSel || JSel || PCsrc);

  always_comb begin
    if (JrSel)
      target = jr_addr & ~32'h3;
    else if (JSel)
      target = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};
    else
      target = pc_plus4_q + (branch_imm << 2);
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc_plus4_d   = pc_plus4_q;
    valid_d      = valid_q;
    skid_d       = skid_q;
    deliver      = 1'b0;
    deliver_word = imem_rdata;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        // A redirect squashes whatever memory returns this cycle.
        if (redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
          instr_d = 32'h0;
        end else if (imem_ready && !stall) begin
          deliver = 1'b1;
        end else if (imem_ready) begin
          skid_d  = imem_rdata;
          state_d = HOLD;
        end else if (!stall) begin
          valid_d = 1'b0;
          instr_d = 32'h0;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
          instr_d = 32'h0;
          skid_d  = 32'h0;
          state_d = FETCH;
        end else if (!stall) begin
          deliver      = 1'b1;
          deliver_word = skid_q;
          state_d      = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    if (deliver) begin
      instr_d    = deliver_word;
      pc_plus4_d = seq_pc;
      valid_d    = 1'b1;
      pc_d       = seq_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= 32'h0;
      instr_q    <= 32'h0;
      pc_plus4_q <= 32'h0;
      skid_q     <= 32'h0;
      valid_q    <= 1'b0;
      imem_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      skid_q     <= skid_d;
      valid_q    <= valid_d;
      imem_req_q <= (state_d == FETCH);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fetch_count_q <= 32'h0;
    else if (deliver && (fetch_count_q != 32'hFFFF_FFFF))
      fetch_count_q <= fetch_count_q + 32'd1;
  end

  assign fetch_count = fetch_count_q;
`endif

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign opcode    = instr_q[31:26];
  assign func      = instr_q[5:0];
  assign pc_plus4  = pc_plus4_q;
  assign valid     = valid_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: imem_req  output  1  fetch request to instruction memory.
REQ-004 SHALL have port: imem_addr  output  32  byte address of requested word (always word-aligned).
REQ-005 SHALL have port: imem_ready  input  1  imem_rdata valid for current imem_addr this cycle.
REQ-006 SHALL have port: imem_rdata  input  32  instruction word.
REQ-007 SHALL have port: stall  input  1  decode cannot accept; hold IF/ID contents.
REQ-008 SHALL have port: PCsrc  input  1  taken conditional branch for decoded instruction.
REQ-009 SHALL have port: JSel  input  1  J/JAL for decoded instruction.
REQ-010 SHALL have port: JrSel  input  1  JR for decoded instruction.
REQ-011 SHALL have port: branch_imm  input  32  sign-extended 16-bit branch offset, in words.
REQ-012 SHALL have port: jr_addr  input  32  register-sourced jump target.
REQ-013 SHALL have ports: instr  output  32; opcode  output  6 (instr[31:26]); func  output  6 (instr[5:0]).
REQ-014 SHALL have port: pc_plus4  output  32  address of decoded instruction + 4 (JAL link value).
REQ-015 SHALL have port: valid  output  1  instr/pc_plus4 hold a live instruction.

Function
REQ-016 SHALL implement states IDLE, FETCH, HOLD; IDLE -> FETCH unconditionally one cycle after reset release.
REQ-017 In FETCH SHALL drive imem_req=1, imem_addr=pc; in IDLE, imem_req=0; in HOLD, imem_req=0.
REQ-018 On FETCH with imem_ready=1 and stall=0: instr<=imem_rdata, pc_plus4<=pc+4, valid<=1, pc<=next_pc.
REQ-019 On FETCH with imem_ready=1 and stall=1: capture imem_rdata into a 32-bit skid register, go HOLD, pc unchanged.
REQ-020 In HOLD with stall=0: move skid word into instr, pc_plus4<=pc+4, valid<=1, pc<=next_pc, return FETCH.
REQ-021 On FETCH with imem_ready=0: valid<=0 unless stall=1 (then instr/valid held), pc unchanged.
REQ-022 stall=1 SHALL freeze instr, pc_plus4, valid; redirect inputs SHALL be ignored while stall=1.
REQ-023 Redirect, evaluated only when valid=1 and stall=0, priority JrSel > JSel > PCsrc: targets jr_addr; {pc_plus4[31:28], instr[25:0], 2'b00}; pc_plus4 + (branch_imm << 2), 32-bit wraparound.
REQ-024 On redirect, next_pc SHALL be the target, any word returned that cycle or held in skid SHALL be discarded, valid<=0 next cycle, state -> FETCH.
REQ-025 Without redirect, next_pc SHALL be pc+4, wrapping 0xFFFF_FFFC -> 0x0000_0000.
REQ-026 jr_addr[1:0] SHALL be forced to 0 when loaded into pc.
REQ-027 opcode/func SHALL be combinational slices of instr; when valid=0, instr SHALL read 0x0000_0000 (NOP, opcode 000000).
REQ-028 Latency: accepted imem word appears on instr exactly one cycle after imem_ready sample.

Reset
REQ-029 rst_n=0 SHALL immediately force pc=0x0000_0000, state=IDLE, instr=0, pc_plus4=0, valid=0, skid cleared, imem_req=0.
REQ-030 Reset asserted mid-fetch or in HOLD SHALL abandon the transaction; first request after release targets 0x0000_0000.

Configuration
REQ-031 Macro FETCH_PERF_CNT_EN defined: add output fetch_count (32) counting instructions delivered to decode (valid rising into new word), saturating at 0xFFFF_FFFF, reset to 0.
REQ-032 Macro FETCH_PERF_CNT_EN undefined: no fetch_count port, no counter logic; all other behaviour identical.

Verification
REQ-033 Reset release, imem_ready=1 constant, rdata=0x2008_0005 -> imem_addr 0x0,0x4,0x8 on successive cycles; instr=0x2008_0005, opcode=001000, pc_plus4=0x4 one cycle after first ready.
REQ-034 valid=1, pc_plus4=0x10, PCsrc=1, branch_imm=0xFFFF_FFFE -> next imem_addr=0x8, valid=0 for one cycle.
REQ-035 JrSel=1 and JSel=1 together, jr_addr=0x0000_0043 -> next imem_addr=0x0000_0040.
REQ-036 stall=1 while imem_ready=1 with rdata=0xAC01_0004 -> state HOLD, imem_req=0, instr unchanged; stall=0 -> instr=0xAC01_0004 next cycle, no refetch.
REQ-037 pc=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000; rst_n pulsed low during FETCH with imem_ready=0 -> all outputs reset at once, restart at 0x0.
REQ-038 With FETCH_PERF_CNT_EN: 10 delivered instructions, 2 squashed by redirect -> fetch_count=10.
